// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot/periodic reload
// and a single-cycle registered expiry pulse.
module down_timer #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      cnt,
  output logic [7:0]            q,
  output logic                  zero,
  output logic                  expire,
  output logic                  busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [PRESCALE_W-1:0] presc_reg_q, presc_reg_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic                  expire_q, expire_d;
  logic                  tick;

  assign tick = (state_q == RUN) && (presc_cnt_q == presc_reg_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    presc_reg_d = presc_reg_q;
    presc_cnt_d = presc_cnt_q;
    expire_d    = 1'b0;
    if (load) begin
      reload_d    = load_val;
      cnt_d       = load_val;
      presc_reg_d = prescale;
      presc_cnt_d = '0;
      state_d     = IDLE;
    end else if (stop && state_q == RUN) begin
      state_d = PAUSE;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (start && cnt_q != '0) state_d = RUN;
        end
        DONE: begin
          if (start && reload_q != '0) begin
            state_d     = RUN;
            cnt_d       = reload_q;
            presc_cnt_d = '0;
          end
        end
        RUN: begin
          if (tick) begin
            presc_cnt_d = '0;
            // Expiry on the 1 -> next step, so 0 is only ever seen in DONE
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (cnt_q == CNT_ONE) begin
              expire_d = 1'b1;
              if (periodic) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = DONE;
              end
            end
          end else begin
            presc_cnt_d = presc_cnt_q + PSC_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reload_q    <= '0;
      presc_reg_q <= '0;
      presc_cnt_q <= '0;
      expire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      presc_reg_q <= presc_reg_d;
      presc_cnt_q <= presc_cnt_d;
      expire_q    <= expire_d;
    end
  end

  assign cnt    = cnt_q;
  assign q      = cnt_q[WIDTH-1 -: 8];
  assign zero   = (cnt_q == '0);
  assign expire = expire_q;
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios plus random control traffic
// compared cycle by cycle against a behavioural timer model.
module tb_down_timer;

  logic        clk = 1'b0;
  logic        rst, load, periodic, start, stop;
  logic [31:0] load_val;
  logic [15:0] prescale;
  logic [31:0] cnt;
  logic [7:0]  q;
  logic        zero, expire, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model
  logic [31:0] m_cnt, m_reload;
  int          m_psc, m_phase;
  bit          m_run, m_pause, m_done, m_expire;

  down_timer #(.WIDTH(32), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .prescale(prescale), .periodic(periodic), .start(start),
    .stop(stop), .cnt(cnt), .q(q), .zero(zero),
    .expire(expire), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_step();
    m_expire = 0;
    if (rst) begin
      m_cnt = 0; m_reload = 0; m_psc = 0; m_phase = 0;
      m_run = 0; m_pause = 0; m_done = 0;
    end else if (load) begin
      m_cnt = load_val; m_reload = load_val;
      m_psc = int'(prescale); m_phase = 0;
      m_run = 0; m_pause = 0; m_done = 0;
    end else if (m_run && stop) begin
      m_run = 0; m_pause = 1;
    end else if (m_run) begin
      if (m_phase == m_psc) begin
        m_phase = 0;
        if (m_cnt == 1) begin
          m_expire = 1;
          if (periodic) m_cnt = m_reload;
          else begin
            m_cnt = 0; m_run = 0; m_done = 1;
          end
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else begin
        m_phase++;
      end
    end else if (start) begin
      if (m_done) begin
        if (m_reload != 0) begin
          m_done = 0; m_run = 1; m_cnt = m_reload; m_phase = 0;
        end
      end else if (m_cnt != 0) begin
        m_run = 1; m_pause = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("cnt", cnt, m_cnt);
    check("q", {24'd0, q}, {24'd0, m_cnt[31:24]});
    check("zero", {31'd0, zero}, {31'd0, m_cnt == 0});
    check("expire", {31'd0, expire}, {31'd0, m_expire});
    check("busy", {31'd0, busy}, {31'd0, m_run});
    @(negedge clk);
    rst = 0; load = 0; start = 0; stop = 0;
  endtask

  task automatic do_load(input logic [31:0] v, input logic [15:0] p);
    load = 1; load_val = v; prescale = p;
    cycle();
  endtask

  int n_exp, n_zero;

  initial begin
    rst = 1; load = 0; start = 0; stop = 0; periodic = 0;
    load_val = 0; prescale = 0;
    m_cnt = 'x; m_reload = 0; m_psc = 0; m_phase = 0;
    m_run = 0; m_pause = 0; m_done = 0; m_expire = 0;
    @(negedge clk);
    rst = 1;
    cycle();
    check("rst_cnt", cnt, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    start = 1;
    cycle();
    check("start_at_zero_busy", {31'd0, busy}, 32'd0);

    // one-shot: 3, prescale 0
    periodic = 0;
    do_load(32'd3, 16'd0);
    start = 1;
    cycle();
    check("os_c1", cnt, 32'd3);
    cycle(); check("os_c2", cnt, 32'd2);
    cycle(); check("os_c3", cnt, 32'd1);
    check("os_c3_exp", {31'd0, expire}, 32'd0);
    cycle(); check("os_c4", cnt, 32'd0);
    check("os_c4_exp", {31'd0, expire}, 32'd1);
    check("os_c4_busy", {31'd0, busy}, 32'd0);
    cycle(); check("os_c5_exp", {31'd0, expire}, 32'd0);

    // restart from DONE with reload 2
    do_load(32'd2, 16'd0);
    start = 1; cycle();
    cycle(); cycle();
    check("rd_done", {31'd0, expire}, 32'd1);
    start = 1; cycle();
    check("rd_cnt", cnt, 32'd2);
    check("rd_busy", {31'd0, busy}, 32'd1);
    cycle(); cycle();
    check("rd_exp2", {31'd0, expire}, 32'd1);

    // periodic: 4, prescale 2 -> 5 expiries in 60 cycles
    periodic = 1;
    do_load(32'd4, 16'd2);
    start = 1; cycle();
    n_exp = 0; n_zero = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      n_exp += int'(expire);
      n_zero += int'(zero);
    end
    check("per_expires", n_exp, 32'd5);
    check("per_zero", n_zero, 32'd0);

    // pause/resume; stop lands on a tick
    periodic = 0;
    do_load(32'd10, 16'd0);
    start = 1; cycle();
    cycle(); cycle(); cycle();
    check("pr_cnt7", cnt, 32'd7);
    stop = 1; cycle();
    for (int i = 0; i < 20; i++) cycle();
    check("pr_hold", cnt, 32'd7);
    check("pr_busy", {31'd0, busy}, 32'd0);
    start = 1; cycle();
    n_exp = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      n_exp += int'(expire);
    end
    check("pr_exp", {31'd0, expire}, 32'd1);
    check("pr_nexp", n_exp, 32'd1);

    // priority
    load = 1; start = 1; stop = 1; load_val = 5; prescale = 0;
    cycle();
    check("pri_cnt", cnt, 32'd5);
    check("pri_busy", {31'd0, busy}, 32'd0);
    start = 1; cycle();
    for (int i = 0; i < 4; i++) cycle();
    do_load(32'd9, 16'd0);
    check("pri_ld_exp", {31'd0, expire}, 32'd0);
    check("pri_ld_cnt", cnt, 32'd9);
    start = 1; cycle(); cycle();
    rst = 1; cycle();
    check("pri_rst_cnt", cnt, 32'd0);
    check("pri_rst_busy", {31'd0, busy}, 32'd0);

    do_load(32'h0100_0000, 16'd0);
    check("q_top", {24'd0, q}, 32'h01);

    // random control traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) periodic = $urandom_range(0, 1);
      load_val = ($urandom_range(0, 9) == 0) ? $urandom()
                                              : $urandom_range(0, 6);
      prescale = 16'($urandom_range(0, 3));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer. It is the countdown counterpart of the free-running up-counter block. A reload value and prescale are loaded, and on start the counter decrements once per prescaled tick. On reaching zero it either stops (one-shot) or reloads and continues (periodic). It signals expiry with a single-cycle pulse, so it serves as the timeout/period source for control logic that currently compares up-counter values.

Parameters:
WIDTH, 32, counter and reload width (must be >= 8)
PRESCALE_W, 16, prescale counter width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
load  input  1  pulse; capture load_val and prescale, stop timer
load_val  input  WIDTH  reload value
prescale  input  PRESCALE_W  tick divider; one tick every prescale+1 RUN cycles
periodic  input  1  1 = auto-reload on expiry; 0 = one-shot; sampled on the expiry tick
start  input  1  start/resume counting
stop  input  1  pause counting
cnt  output  WIDTH  current count (registered)
q  output  8  cnt[WIDTH-1:WIDTH-8]
zero  output  1  cnt == 0 (combinational from cnt)
expire  output  1  one-cycle registered pulse on expiry
busy  output  1  state == RUN (registered state decode)

Behaviour:
- Reset: state IDLE; cnt, reload register, prescale register and prescaler counter all 0; expire 0; busy 0; zero 1.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- Control priority per cycle: rst > load > stop > start.
- load (any state):
  - reload_reg <= load_val; cnt <= load_val; presc_reg <= prescale; presc_cnt <= 0.
  - Next state IDLE. Same-cycle start and stop are ignored.
- start:
  - IDLE/PAUSE -> RUN when cnt != 0. If cnt == 0, start is ignored and the state is unchanged.
  - DONE -> RUN, with cnt <= reload_reg and presc_cnt <= 0. Ignored if reload_reg == 0.
  - Ignored in RUN.
- stop:
  - RUN -> PAUSE. cnt and presc_cnt hold.
  - No effect in other states.
- Prescaler:
  - In RUN, tick = (presc_cnt == presc_reg), combinational.
  - On tick, presc_cnt <= 0; otherwise presc_cnt increments.
  - Frozen outside RUN.
  - presc_reg == 0 gives a tick every RUN cycle.
- Decrement: on a tick in RUN with no stop/load in the same cycle:
  - cnt > 1: cnt <= cnt - 1.
  - cnt == 1 and periodic == 1: cnt <= reload_reg; expire <= 1; stay in RUN. The value 0 is never shown.
  - cnt == 1 and periodic == 0: cnt <= 0; expire <= 1; -> DONE.
- expire is high exactly one cycle: the cycle after the expiry tick, concurrent with the new cnt value. It is 0 in all other cycles.
- Latency: first RUN cycle is the cycle after the start edge. Expiry tick falls reload*(prescale+1) cycles after that. Periodic period is reload*(prescale+1) cycles.
- Simultaneous tick + stop: stop wins; no decrement, no expire.
- Simultaneous tick + load: load wins; no expire.
- Reset mid-RUN: immediate return to reset values at the next edge; no expire.
- periodic changed while running: only the value at the expiry tick matters.
- Reload value 1, periodic: expire every prescale+1 cycles; cnt stays 1.
- No underflow path exists: cnt never wraps from 0 to all-ones.

Test Plan:
1. Reset, then check outputs -> cnt=0, zero=1, busy=0, expire=0, state IDLE. Start with cnt=0 -> stays IDLE.
2. One-shot: load 3, prescale 0, periodic 0, start at cycle 0 -> cnt shows 2, 1, 0 in cycles 2, 3, 4. expire=1 only in cycle 4. busy falls in cycle 4 (DONE).
3. Periodic: load 4, prescale 2, periodic 1, start -> expire every 12 cycles, cnt reloads 1 -> 4, zero never asserted. Run 5 periods.
4. Pause/resume: load 10, prescale 0, start, stop after 3 ticks -> cnt holds 7 for 20 cycles. Start -> resumes, expires 7 cycles later. Stop coinciding with a tick -> no decrement.
5. Priority: load(5) with start and stop in the same cycle -> cnt=5, IDLE. Load during RUN on an expiry tick -> no expire, cnt=new value. rst mid-RUN -> all reset values, no expire.
6. Restart from DONE: after a one-shot expiry with reload 2, start -> cnt=2, RUN, expire again 2 cycles later. Load 32'h0100_0000 -> q=8'h01.
